// File: rtl/proj_unidade_controle_pkg.sv
// proj_unidade_controle_pkg: state codes and widths shared by the chess move-training control unit.
//   ESTADO_W            width of the state register / db_estado
//   E_INICIAL..E_FIM_JOGO  4-bit state codes, also used for db_estado display
package proj_unidade_controle_pkg;

    localparam int ESTADO_W = 4;

    localparam logic [ESTADO_W-1:0] E_INICIAL       = 4'd0;
    localparam logic [ESTADO_W-1:0] E_PREPARACAO    = 4'd1;
    localparam logic [ESTADO_W-1:0] E_GERA_JOGADA   = 4'd2;
    localparam logic [ESTADO_W-1:0] E_ESPERA_JOGADA = 4'd3;
    localparam logic [ESTADO_W-1:0] E_REGISTRA      = 4'd4;
    localparam logic [ESTADO_W-1:0] E_COMPARA       = 4'd5;
    localparam logic [ESTADO_W-1:0] E_ACERTO        = 4'd6;
    localparam logic [ESTADO_W-1:0] E_ERRO          = 4'd7;
    localparam logic [ESTADO_W-1:0] E_FIM_JOGO      = 4'd8;

endpackage

// File: rtl/proj_unidade_controle_contador_penalidade.sv
// contador_penalidade: 4-bit up-counter timing the wrong-move penalty.
//   clock  in   system clock, rising edge
//   reset  in   asynchronous, active-low; clears the count
//   zera   in   synchronous clear (priority over conta)
//   conta  in   count enable
//   fim    out  terminal flag, high while the count equals PENALIDADE-1
module contador_penalidade #(
    parameter int PENALIDADE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [3:0] valor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            valor <= 4'd0;
        else if (zera)
            valor <= 4'd0;
        else if (conta)
            valor <= valor + 4'd1;
    end

    assign fim = valor == 4'(PENALIDADE - 1);

endmodule

// File: rtl/proj_unidade_controle.sv
// proj_unidade_controle: Moore control unit sequencing the chess move-training datapath.
//   clock, reset        rising-edge clock; asynchronous active-low reset
//   iniciar             start/restart request
//   temJogada           one-cycle pulse, player move available
//   acertou             played move equals expected move
//   fimT                game timer expired
//   novaJogada          request next target move
//   registraR           latch player move
//   zeraR, zeraT, zeraP clear move registers / timer / score
//   contaT, decresceT   advance timer / apply time penalty
//   contaP              increment score
//   pronto              game over
//   db_estado           current state code
// Optional feature: define PENALIDADE_EN to hold erro for PENALIDADE cycles with decresceT high.
module proj_unidade_controle
    import proj_unidade_controle_pkg::*;
#(
    parameter int PENALIDADE = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                temJogada,
    input  logic                acertou,
    input  logic                fimT,
    output logic                novaJogada,
    output logic                registraR,
    output logic                zeraR,
    output logic                zeraT,
    output logic                zeraP,
    output logic                contaT,
    output logic                decresceT,
    output logic                contaP,
    output logic                pronto,
    output logic [ESTADO_W-1:0] db_estado
);

    logic [ESTADO_W-1:0] estado, proximo;
    logic                emErro;
    logic                ultimoPen;

    assign emErro = estado == E_ERRO;

`ifdef PENALIDADE_EN
    // Counter is held at 0 outside erro, so it restarts from 0 on every entry.
    contador_penalidade #(.PENALIDADE(PENALIDADE)) uPenalidade (
        .clock (clock),
        .reset (reset),
        .zera  (!emErro),
        .conta (emErro),
        .fim   (ultimoPen)
    );
    assign decresceT = emErro;
`else
    // Without the penalty, erro is a single cycle: it is always its own last cycle.
    assign ultimoPen = 1'b1;
    assign decresceT = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            estado <= E_INICIAL;
        else
            estado <= proximo;
    end

    always_comb begin
        proximo = E_INICIAL;
        case (estado)
            E_INICIAL:       proximo = iniciar ? E_PREPARACAO : E_INICIAL;
            E_PREPARACAO:    proximo = E_GERA_JOGADA;
            E_GERA_JOGADA:   proximo = E_ESPERA_JOGADA;
            E_ESPERA_JOGADA: proximo = fimT ? E_FIM_JOGO : temJogada ? E_REGISTRA : E_ESPERA_JOGADA;
            E_REGISTRA:      proximo = fimT ? E_FIM_JOGO : E_COMPARA;
            E_COMPARA:       proximo = fimT ? E_FIM_JOGO : acertou ? E_ACERTO : E_ERRO;
            E_ACERTO:        proximo = fimT ? E_FIM_JOGO : E_GERA_JOGADA;
            E_ERRO:          proximo = fimT ? E_FIM_JOGO : ultimoPen ? E_ESPERA_JOGADA : E_ERRO;
            E_FIM_JOGO:      proximo = iniciar ? E_PREPARACAO : E_FIM_JOGO;
            default:         proximo = E_INICIAL;
        endcase
    end

    assign novaJogada = estado == E_GERA_JOGADA;
    assign registraR  = estado == E_REGISTRA;
    assign zeraT      = estado == E_PREPARACAO;
    assign zeraP      = estado == E_PREPARACAO;
    assign zeraR      = estado == E_PREPARACAO || estado == E_GERA_JOGADA || (emErro && ultimoPen);
    assign contaP     = estado == E_ACERTO;
    assign pronto     = estado == E_FIM_JOGO;
    // The timer runs in every waiting/playing state except while a penalty is being applied.
    assign contaT     = estado == E_ESPERA_JOGADA || estado == E_REGISTRA || estado == E_COMPARA ||
                        estado == E_ACERTO || (emErro && !decresceT);
    assign db_estado  = estado;

endmodule

// File: tb/tb_proj_unidade_controle.sv
// tb_proj_unidade_controle: directed and randomized check of proj_unidade_controle against a game-level model.
module tb_proj_unidade_controle;

    localparam int P = 4;
`ifdef PENALIDADE_EN
    localparam bit PEN_EN = 1'b1;
`else
    localparam bit PEN_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset, iniciar, temJogada, acertou, fimT;
    logic       novaJogada, registraR, zeraR, zeraT, zeraP, contaT, decresceT, contaP, pronto;
    logic [3:0] db_estado;
    logic [12:0] obsv;

    int nComp = 0;
    int nFail = 0;
    int mEst  = 0;
    int mPen  = 0;
    int cntDec, cntP, cntNova, cntReg, cntZeraR;

    always #5 clock = ~clock;

    proj_unidade_controle #(.PENALIDADE(P)) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .temJogada  (temJogada),
        .acertou    (acertou),
        .fimT       (fimT),
        .novaJogada (novaJogada),
        .registraR  (registraR),
        .zeraR      (zeraR),
        .zeraT      (zeraT),
        .zeraP      (zeraP),
        .contaT     (contaT),
        .decresceT  (decresceT),
        .contaP     (contaP),
        .pronto     (pronto),
        .db_estado  (db_estado)
    );

    assign obsv = {db_estado, novaJogada, registraR, zeraR, zeraT, zeraP, contaT, decresceT, contaP, pronto};

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nComp++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected strobes from the game phase: {db, nova, reg, zeraR, zeraT, zeraP, contaT, decT, contaP, pronto}.
    function automatic logic [12:0] esperado(input int e, input int pen);
        logic [3:0] d;
        logic nv, rg, zr, zt, zp, ct, dt, cp, pr;
        d = 4'(e);
        {nv, rg, zr, zt, zp, ct, dt, cp, pr} = '0;
        case (e)
            1: begin zr = 1; zt = 1; zp = 1; end
            2: begin nv = 1; zr = 1; end
            3: ct = 1;
            4: begin rg = 1; ct = 1; end
            5: ct = 1;
            6: begin cp = 1; ct = 1; end
            7: if (PEN_EN) begin dt = 1; zr = (pen == 1); end
               else begin zr = 1; ct = 1; end
            8: pr = 1;
            default: ;
        endcase
        return {d, nv, rg, zr, zt, zp, ct, dt, cp, pr};
    endfunction

    task automatic modelo(input logic ini, input logic tem, input logic ac, input logic fim);
        case (mEst)
            0: mEst = ini ? 1 : 0;
            1: mEst = 2;
            2: mEst = 3;
            3: mEst = fim ? 8 : tem ? 4 : 3;
            4: mEst = fim ? 8 : 5;
            5: begin
                mEst = fim ? 8 : ac ? 6 : 7;
                mPen = P;
            end
            6: mEst = fim ? 8 : 2;
            7: if (fim) mEst = 8;
               else if (!PEN_EN || mPen == 1) mEst = 3;
               else mPen--;
            8: mEst = ini ? 1 : 8;
            default: mEst = 0;
        endcase
    endtask

    task automatic passo(input logic ini, input logic tem, input logic ac, input logic fim);
        @(negedge clock);
        iniciar = ini; temJogada = tem; acertou = ac; fimT = fim;
        @(posedge clock);
        modelo(ini, tem, ac, fim);
        #1;
        confere("saidas", 32'(obsv), 32'(esperado(mEst, mPen)));
        confere("contaT_decresceT", 32'(contaT & decresceT), 32'd0);
        cntDec   += int'(decresceT);
        cntP     += int'(contaP);
        cntNova  += int'(novaJogada);
        cntReg   += int'(registraR);
        cntZeraR += int'(zeraR);
    endtask

    task automatic zeraContagens();
        cntDec = 0; cntP = 0; cntNova = 0; cntReg = 0; cntZeraR = 0;
    endtask

    initial begin
        logic prevTem;
        reset = 1'b0; iniciar = 1'b0; temJogada = 1'b0; acertou = 1'b0; fimT = 1'b0;
        zeraContagens();
        repeat (3) @(posedge clock);
        #1 confere("reset", 32'(obsv), 32'd0);
        @(negedge clock) reset = 1'b1;

        // start-up: 0 -> 1 -> 2 -> 3
        passo(0, 0, 0, 0); confere("ocioso", 32'(db_estado), 32'd0);
        passo(1, 0, 0, 0); confere("preparacao", 32'({zeraT, zeraP, zeraR, db_estado}), 32'h71);
        passo(0, 0, 0, 0); confere("gera", 32'({novaJogada, db_estado}), 32'h12);
        passo(0, 0, 0, 0); confere("espera", 32'(db_estado), 32'd3);

        // correct move: 3,4,5,6,2,3
        zeraContagens();
        passo(0, 1, 0, 0); confere("registra", 32'(db_estado), 32'd4);
        passo(0, 0, 0, 0); confere("compara", 32'(db_estado), 32'd5);
        passo(0, 0, 1, 0); confere("acerto", 32'(db_estado), 32'd6);
        passo(0, 0, 0, 0); confere("nova", 32'(db_estado), 32'd2);
        passo(0, 0, 0, 0); confere("volta", 32'(db_estado), 32'd3);
        confere("n_registraR", 32'(cntReg), 32'd1);
        confere("n_contaP", 32'(cntP), 32'd1);
        confere("n_novaJogada", 32'(cntNova), 32'd1);

        // wrong move: penalty then retry same target
        zeraContagens();
        passo(0, 1, 0, 0);
        passo(0, 0, 0, 0);
        passo(0, 0, 0, 0); confere("erro", 32'(db_estado), 32'd7);
        for (int i = 0; i < 20 && mEst != 3; i++) passo(0, 0, 0, 0);
        confere("erro_volta", 32'(db_estado), 32'd3);
        confere("n_decresceT", 32'(cntDec), PEN_EN ? 32'(P) : 32'd0);
        confere("n_zeraR_erro", 32'(cntZeraR), 32'd1);
        confere("n_nova_erro", 32'(cntNova), 32'd0);

        // fimT during compara beats acertou
        zeraContagens();
        passo(0, 1, 0, 0);
        passo(0, 0, 0, 0);
        passo(0, 0, 1, 1); confere("fim", 32'({pronto, db_estado}), 32'h18);
        passo(0, 0, 0, 0);
        passo(0, 1, 1, 0); confere("pronto_mantido", 32'(pronto), 32'd1);
        confere("n_contaP_fim", 32'(cntP), 32'd0);
        passo(1, 0, 0, 0); confere("reinicio", 32'(db_estado), 32'd1);

        // asynchronous reset while in erro
        passo(0, 0, 0, 0);
        passo(0, 0, 0, 0);
        passo(0, 1, 0, 0);
        passo(0, 0, 0, 0);
        passo(0, 0, 0, 0); confere("erro2", 32'(db_estado), 32'd7);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 confere("reset_async", 32'(obsv), 32'd0);
        mEst = 0; mPen = 0;
        @(posedge clock);
        #1 confere("reset_mantido", 32'(obsv), 32'd0);
        @(negedge clock) reset = 1'b1;
        passo(1, 0, 0, 0);
        passo(0, 0, 0, 0);
        passo(0, 0, 0, 0);
        zeraContagens();
        passo(0, 1, 0, 0);
        passo(0, 0, 0, 0);
        passo(0, 0, 0, 0);
        for (int i = 0; i < 20 && mEst != 3; i++) passo(0, 0, 0, 0);
        confere("pen_pos_reset", 32'(cntDec), PEN_EN ? 32'(P) : 32'd0);
        confere("volta_pos_reset", 32'(db_estado), 32'd3);

        // randomized play
        prevTem = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic ini, tem, ac, fim;
            ini = $urandom_range(7) == 0;
            tem = !prevTem && $urandom_range(3) == 0;
            ac  = 1'($urandom);
            fim = $urandom_range(39) == 0;
            prevTem = tem;
            passo(ini, tem, ac, fim);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule

// File: doc/proj_unidade_controle.md
# proj_unidade_controle

Control unit for the chess move-training game. A Moore state machine that sequences the game datapath: clears the timer, score and move registers, requests a new target move, waits for the player's edge-detected move, latches and compares it, and awards a point or applies a time penalty. It sits beside the datapath in the top level and owns every datapath control strobe.

## Interface
Parameters:
- PENALIDADE, 4: number of cycles `decresceT` is held after a wrong move; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; forces `inicial`
- iniciar  in  1  start/restart game request, level-sampled
- temJogada  in  1  one-cycle pulse: player move available
- acertou  in  1  played move equals expected move
- fimT  in  1  game timer expired
- novaJogada  out  1  request next target from move generator
- registraR  out  1  latch player row/column
- zeraR  out  1  clear move registers and edge detector
- zeraT  out  1  clear game timer
- zeraP  out  1  clear score counter
- contaT  out  1  advance game timer
- decresceT  out  1  apply time penalty
- contaP  out  1  increment score
- pronto  out  1  game over, result stable
- db_estado  out  4  current state code

## Operation
States and codes: inicial 0, preparacao 1, gera_jogada 2, espera_jogada 3, registra 4, compara 5, acerto 6, erro 7, fim_jogo 8; codes 9–15 unused and go to `inicial`.
- inicial: all strobes low; `iniciar` → preparacao.
- preparacao: zeraT, zeraP, zeraR high → gera_jogada.
- gera_jogada: novaJogada, zeraR high → espera_jogada.
- espera_jogada: contaT high; `fimT` → fim_jogo; else `temJogada` → registra; else stay.
- registra: registraR, contaT high → compara.
- compara: contaT high; `acertou` → acerto, else erro.
- acerto: contaP, contaT high → gera_jogada.
- erro: see Configuration; exits to espera_jogada, the same target is retried.
- fim_jogo: pronto high, all other strobes low; `iniciar` → preparacao.

Rules:
- `fimT` has priority over every other condition in registra, compara, acerto and erro; the next state is fim_jogo and no contaP is issued that cycle.
- contaT and decresceT are never high in the same cycle.
- `temJogada` outside espera_jogada is ignored; the edge detector is cleared by zeraR before any wait.
- Score saturation belongs to the score counter, not this block.

## Timing
- Reset: state inicial, every output 0, db_estado 0, penalty counter 0. Asynchronous assert; state leaves inicial only on the first rising edge after deassertion at which iniciar=1.
- All outputs are pure decodes of the state register and penalty counter. No combinational path from any input to any output.
- Move latency: temJogada high at edge N → registraR during cycle N+1 → compare at N+2 → contaP during N+3 → novaJogada during N+4.
- Reset asserted mid-game returns to inicial immediately. Datapath counters are cleared only via preparacao.

## Configuration
- PENALIDADE_EN defined:
  - erro lasts PENALIDADE cycles, with decresceT high and contaT low throughout.
  - A 4-bit counter loads 0 on entry. zeraR is high on the last cycle only, then the state moves to espera_jogada.
  - `fimT` aborts the penalty to fim_jogo.
- Undefined:
  - erro lasts exactly one cycle, with zeraR and contaT high and decresceT constantly 0.
  - The penalty counter is not instantiated.

## Structure
- A shared package holds the state code localparams (E_INICIAL … E_FIM_JOGO, 4-bit) and the state width constant. The top level reuses the codes for db_estado display decoding.
- One natural sub-module, `contador_penalidade`: a 4-bit up-counter with synchronous clear, enable and terminal flag (== PENALIDADE−1). It exists only under PENALIDADE_EN.
- The state register and next-state/output decode live in this module.

## Test plan
- Reset then iniciar=1 for one cycle → db_estado 0→1→2→3. Cycle 1 has zeraT=zeraP=zeraR=1; cycle 2 has novaJogada=1.
- In espera_jogada, temJogada pulse with acertou=1 → registraR one cycle, then contaP exactly one cycle, then novaJogada; db_estado 3,4,5,6,2,3.
- Wrong move, PENALIDADE=4, macro defined → decresceT high exactly 4 cycles and contaT low during them; zeraR on the 4th; returns to state 3 with no novaJogada.
- Same stimulus, macro undefined → one erro cycle, decresceT never high, back to state 3.
- fimT asserted during compara with acertou=1 → next state 8, contaP never pulses; pronto held; iniciar → state 1.
- reset pulled low in state 7 mid-penalty → all outputs 0 asynchronously; later restart shows a full PENALIDADE-cycle penalty.
